// File: rtl/inst_fetch_stepper.sv
// Clk-synchronous instruction-fetch stepper: debounced single-step or free-run PC
// advance, latency-tolerant ROM fetch, byte-wise LED view of the fetched word.
`timescale 1ns/1ps

// state    | meaning
// ST_FETCH | present PC to ROM, arm latency counter, Inst_valid low
// ST_WAIT  | count down ROM latency, capture Rom_data on the last cycle
// ST_READY | Inst_code valid for PC; a step request (or queued one) advances PC
module inst_fetch_stepper #(
    parameter int ADDR_W     = 8,
    parameter int DEB_CYCLES = 131072,
    parameter int RUN_DIV    = 50000000,
    parameter int MEM_LAT    = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Button,
    input  logic              Run,
    input  logic [1:0]        Select,
    output logic [ADDR_W-3:0] Rom_addr,
    input  logic [31:0]       Rom_data,
    output logic [31:0]       PC,
    output logic [31:0]       Inst_code,
    output logic              Inst_valid,
    output logic [7:0]        LED
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int DIV_W = $clog2(RUN_DIV);
    localparam logic [DEB_W-1:0]  DEB_RELOAD = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(RUN_DIV - 1);
    localparam logic [3:0]        LAT_LOAD   = 4'(MEM_LAT);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

    typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_r;
    logic [3:0]        lat_cnt;
    logic              pending;

    logic              btn_meta, btn_sync, deb_level, deb_prev;
    logic [DEB_W-1:0]  deb_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic              run_tick, step_req;

    // Debounced level only follows the synchronised button after DEB_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= DEB_RELOAD;
            div_cnt   <= '0;
        end else begin
            btn_meta <= Button;
            btn_sync <= btn_meta;
            deb_prev <= deb_level;
            if (btn_sync == deb_level) begin
                deb_cnt <= DEB_RELOAD;
            end else if (deb_cnt == '0) begin
                deb_level <= btn_sync;
                deb_cnt   <= DEB_RELOAD;
            end else begin
                deb_cnt <= deb_cnt - DEB_W'(1);
            end
            if (!Run || run_tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign run_tick = Run && (div_cnt == DIV_LAST);
    assign step_req = Run ? run_tick : (deb_level & ~deb_prev);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= ST_FETCH;
            pc_r       <= '0;
            lat_cnt    <= '0;
            pending    <= 1'b0;
            Inst_code  <= '0;
            Inst_valid <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    lat_cnt    <= LAT_LOAD;
                    Inst_valid <= 1'b0;
                    if (step_req) pending <= 1'b1;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (step_req) pending <= 1'b1;
                    // Capture on the final latency cycle so Inst_valid rises MEM_LAT+1 edges after FETCH.
                    if (lat_cnt <= 4'd1) begin
                        Inst_code  <= Rom_data;
                        Inst_valid <= 1'b1;
                        state      <= ST_READY;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                ST_READY: begin
                    if (step_req || pending) begin
                        pc_r       <= pc_r + PC_STEP;
                        pending    <= 1'b0;
                        Inst_valid <= 1'b0;
                        state      <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    assign Rom_addr = pc_r[ADDR_W-1:2];
    assign PC       = 32'(pc_r);

    always_comb begin
        LED = Inst_code[7:0];
        case (Select)
            2'd0: LED = Inst_code[7:0];
            2'd1: LED = Inst_code[15:8];
            2'd2: LED = Inst_code[23:16];
            2'd3: LED = Inst_code[31:24];
            default: LED = Inst_code[7:0];
        endcase
    end

endmodule
